// File: rtl/linear_layer_backprop.sv
// rtl/linear_layer_backprop.sv - sequential W^T*g backward engine for one linear layer
// One MAC per cycle walks o fastest, i slowest; grad_out only moves on the completing edge.
module linear_layer_backprop #(
  parameter int WIDTH = 16,
  parameter int NIN = 4,
  parameter int NOUT = 4,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [0:NOUT-1][WIDTH-1:0]     grad_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [0:NIN-1][WIDTH-1:0]      grad_out,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int ACCW = 2*WIDTH + $clog2(NOUT) + 1;
  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int OW = (NOUT > 1) ? $clog2(NOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [0:NOUT-1][WIDTH-1:0]  r_g;
  logic signed [ACCW-1:0]      r_acc;
  logic [IW-1:0]               r_i;
  logic [OW-1:0]               r_o;
  logic [0:NIN-1][WIDTH-1:0]   r_res;
  logic [0:NIN-1][WIDTH-1:0]   r_grad_out;

  logic [WIDTH-1:0]            w_wmat [NOUT][NIN];
  logic signed [WIDTH-1:0]     w_weight;
  logic signed [WIDTH-1:0]     w_gval;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACCW-1:0]      w_sum;
  logic                        w_last_o;
  logic                        w_last_i;
  logic [0:NIN-1][WIDTH-1:0]   w_res_next;

  for (genvar go = 0; go < NOUT; go++) begin : g_row
    for (genvar gi = 0; gi < NIN; gi++) begin : g_col
      assign w_wmat[go][gi] = WEIGHTS_MATRIX_FLAT[WIDTH*(go*NIN+gi) +: WIDTH];
    end
  end

  always_comb begin
    w_weight   = $signed(w_wmat[r_o][r_i]);
    w_gval     = $signed(r_g[r_o]);
    w_prod     = (2*WIDTH)'(w_weight) * (2*WIDTH)'(w_gval);
    w_sum      = r_acc + ACCW'(w_prod);
    w_last_o   = (r_o == OW'(NOUT-1));
    w_last_i   = (r_i == IW'(NIN-1));
    // Result buffer as it will look after this edge, so the final copy includes the last term.
    w_res_next = r_res;
    w_res_next[r_i] = w_sum[WIDTH-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (w_last_o && w_last_i) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g        <= '0;
      r_acc      <= '0;
      r_i        <= '0;
      r_o        <= '0;
      r_res      <= '0;
      r_grad_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_g   <= grad_in;
            r_acc <= '0;
            r_i   <= '0;
            r_o   <= '0;
          end
        end
        S_COMPUTE: begin
          if (w_last_o) begin
            r_res <= w_res_next;
            r_acc <= '0;
            r_o   <= '0;
            if (w_last_i) begin
              r_i        <= '0;
              r_grad_out <= w_res_next;
            end else begin
              r_i <= r_i + IW'(1);
            end
          end else begin
            r_acc <= w_sum;
            r_o   <= r_o + OW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign grad_out = r_grad_out;

endmodule

// File: tb/tb_linear_layer_backprop.sv
// tb/tb_linear_layer_backprop.sv - scoreboard bench for linear_layer_backprop
module tb_linear_layer_backprop;

  localparam logic [255:0] W_ID = {16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0,
                                   16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
  localparam logic [95:0]  W_23 = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [255:0] W_RND = {16'h8000, 16'h7FFF, 16'h1234, 16'hFEDC, 16'h0003, 16'hFFFD,
                                    16'h4000, 16'hC000, 16'h0101, 16'hABCD, 16'h0007, 16'hFFF9,
                                    16'h2222, 16'hDDDD, 16'h7FFE, 16'h8001};
  localparam int N_RND = 100;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [63:0] sb_q[$];

  logic [63:0] id_g, id_o, rnd_g, rnd_o;
  logic        id_iv, id_ir, id_ov, id_or;
  logic        rnd_iv, rnd_ir, rnd_ov, rnd_or;
  logic [47:0] d23_g;
  logic [31:0] d23_o;
  logic        d23_iv, d23_ir, d23_ov, d23_or;
  logic [15:0] s0_g, s1_g, s2_g, s0_o, s1_o, s2_o;
  logic        s_iv, s_or, s0_ir, s1_ir, s2_ir, s0_ov, s1_ov, s2_ov;

  linear_layer_backprop #(.WIDTH(16), .NIN(4), .NOUT(4), .WEIGHTS_MATRIX_FLAT(W_ID)) u_id (
    .clk(clk), .rst(rst), .grad_in(id_g), .in_valid(id_iv), .in_ready(id_ir),
    .grad_out(id_o), .out_valid(id_ov), .out_ready(id_or));

  linear_layer_backprop #(.WIDTH(16), .NIN(2), .NOUT(3), .WEIGHTS_MATRIX_FLAT(W_23)) u_23 (
    .clk(clk), .rst(rst), .grad_in(d23_g), .in_valid(d23_iv), .in_ready(d23_ir),
    .grad_out(d23_o), .out_valid(d23_ov), .out_ready(d23_or));

  linear_layer_backprop #(.WIDTH(16), .NIN(1), .NOUT(1), .WEIGHTS_MATRIX_FLAT(16'hFFFD)) u_s0 (
    .clk(clk), .rst(rst), .grad_in(s0_g), .in_valid(s_iv), .in_ready(s0_ir),
    .grad_out(s0_o), .out_valid(s0_ov), .out_ready(s_or));

  linear_layer_backprop #(.WIDTH(16), .NIN(1), .NOUT(1), .WEIGHTS_MATRIX_FLAT(16'h4000)) u_s1 (
    .clk(clk), .rst(rst), .grad_in(s1_g), .in_valid(s_iv), .in_ready(s1_ir),
    .grad_out(s1_o), .out_valid(s1_ov), .out_ready(s_or));

  linear_layer_backprop #(.WIDTH(16), .NIN(1), .NOUT(1), .WEIGHTS_MATRIX_FLAT(16'h8000)) u_s2 (
    .clk(clk), .rst(rst), .grad_in(s2_g), .in_valid(s_iv), .in_ready(s2_ir),
    .grad_out(s2_o), .out_valid(s2_ov), .out_ready(s_or));

  linear_layer_backprop #(.WIDTH(16), .NIN(4), .NOUT(4), .WEIGHTS_MATRIX_FLAT(W_RND)) u_rnd (
    .clk(clk), .rst(rst), .grad_in(rnd_g), .in_valid(rnd_iv), .in_ready(rnd_ir),
    .grad_out(rnd_o), .out_valid(rnd_ov), .out_ready(rnd_or));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_rnd(input logic [63:0] g);
    logic [0:3][15:0] gv;
    logic [0:3][15:0] r;
    longint s;
    gv = g;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int o = 0; o < 4; o++)
        s += longint'($signed(W_RND[16*(o*4+i) +: 16])) * longint'($signed(gv[o]));
      r[i] = s[15:0];
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_total++; if (id_ir !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", id_ir); else n_pass++;
    n_total++; if (id_ov !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", id_ov); else n_pass++;
    n_total++; if (id_o !== 64'd0) $display("FAIL reset_grad_out got=%h exp=0", id_o); else n_pass++;
    n_total++; if (d23_ir !== 1'b1 || d23_ov !== 1'b0) $display("FAIL reset_23 ir=%b ov=%b exp=1/0", d23_ir, d23_ov); else n_pass++;
  endtask

  task automatic test_identity();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    id_g = {16'd1, 16'd2, 16'd3, 16'd4}; id_iv = 1'b1; id_or = 1'b1;
    n_total++; if (id_ir !== 1'b1) $display("FAIL id_accept in_ready=%b exp=1", id_ir); else n_pass++;
    sb_q.push_back({16'd1, 16'd2, 16'd3, 16'd4});
    @(negedge clk); id_iv = 1'b0; id_g = '1;
    lat = 0;
    while (id_ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_total++; if (lat != 16) $display("FAIL id_latency got=%0d exp=16", lat); else n_pass++;
    n_total++;
    if (sb_q.size() == 0) $display("FAIL id_scoreboard_empty got=%h", id_o);
    else begin exp = sb_q.pop_front(); if (id_o !== exp) $display("FAIL id_result got=%h exp=%h", id_o, exp); else n_pass++; end
    @(negedge clk);
    n_total++; if (id_ov !== 1'b0) $display("FAIL id_valid_pulse got=%b exp=0", id_ov); else n_pass++;
    n_total++; if (id_ir !== 1'b1) $display("FAIL id_back_idle got=%b exp=1", id_ir); else n_pass++;
  endtask

  task automatic test_nin2_nout3();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    d23_g = {16'd1, 16'd1, 16'd1}; d23_iv = 1'b1; d23_or = 1'b1;
    n_total++; if (d23_ir !== 1'b1) $display("FAIL d23_accept got=%b exp=1", d23_ir); else n_pass++;
    sb_q.push_back(64'({16'd9, 16'd12}));
    @(negedge clk); d23_iv = 1'b0; d23_g = '0;
    lat = 0;
    while (d23_ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_total++; if (lat != 6) $display("FAIL d23_latency got=%0d exp=6", lat); else n_pass++;
    n_total++;
    if (sb_q.size() == 0) $display("FAIL d23_scoreboard_empty got=%h", d23_o);
    else begin exp = sb_q.pop_front(); if (64'(d23_o) !== exp) $display("FAIL d23_result got=%h exp=%h", d23_o, exp); else n_pass++; end
    @(negedge clk);
  endtask

  task automatic test_signed_wrap();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    s0_g = 16'd7; s1_g = 16'd4; s2_g = 16'hFFFF; s_iv = 1'b1; s_or = 1'b1;
    n_total++; if (s0_ir !== 1'b1) $display("FAIL s_accept got=%b exp=1", s0_ir); else n_pass++;
    sb_q.push_back(64'(16'hFFEB));
    sb_q.push_back(64'(16'h0000));
    sb_q.push_back(64'(16'h8000));
    @(negedge clk); s_iv = 1'b0;
    lat = 0;
    while (s0_ov !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_total++; if (lat != 1) $display("FAIL s_latency got=%0d exp=1", lat); else n_pass++;
    n_total++;
    if (sb_q.size() < 3) $display("FAIL s_scoreboard_short size=%0d exp=3", sb_q.size());
    else begin
      n_pass++;
      exp = sb_q.pop_front();
      n_total++; if (64'(s0_o) !== exp) $display("FAIL s_neg_mul got=%h exp=%h", s0_o, exp); else n_pass++;
      exp = sb_q.pop_front();
      n_total++; if (64'(s1_o) !== exp) $display("FAIL s_wrap_zero got=%h exp=%h", s1_o, exp); else n_pass++;
      exp = sb_q.pop_front();
      n_total++; if (64'(s2_o) !== exp) $display("FAIL s_wrap_min got=%h exp=%h", s2_o, exp); else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    id_g = {16'd5, 16'd6, 16'd7, 16'd8}; id_iv = 1'b1; id_or = 1'b0;
    n_total++; if (id_ir !== 1'b1) $display("FAIL bp_accept got=%b exp=1", id_ir); else n_pass++;
    sb_q.push_back({16'd5, 16'd6, 16'd7, 16'd8});
    @(negedge clk); id_iv = 1'b0;
    lat = 0;
    while (id_ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin id_g = {16'd9, 16'd10, 16'd11, 16'd12}; id_iv = 1'b1; end
      n_total++; if (id_ov !== 1'b1) $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, id_ov); else n_pass++;
      n_total++; if (id_ir !== 1'b0) $display("FAIL bp_hold_ready c=%0d got=%b exp=0", c, id_ir); else n_pass++;
      n_total++; if (id_o !== {16'd5, 16'd6, 16'd7, 16'd8}) $display("FAIL bp_hold_data c=%0d got=%h exp=0005000600070008", c, id_o); else n_pass++;
      @(negedge clk);
    end
    id_or = 1'b1;
    n_total++;
    if (sb_q.size() == 0) $display("FAIL bp_scoreboard_empty got=%h", id_o);
    else begin exp = sb_q.pop_front(); if (id_o !== exp || id_ov !== 1'b1) $display("FAIL bp_result got=%h v=%b exp=%h", id_o, id_ov, exp); else n_pass++; end
    @(negedge clk);
    n_total++; if (id_ir !== 1'b1 || id_ov !== 1'b0) $display("FAIL bp_release ir=%b ov=%b exp=1/0", id_ir, id_ov); else n_pass++;
    if (id_iv && id_ir) sb_q.push_back({16'd9, 16'd10, 16'd11, 16'd12});
    @(negedge clk); id_iv = 1'b0;
    lat = 0;
    while (id_ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_total++; if (lat != 16) $display("FAIL bp_pending_latency got=%0d exp=16", lat); else n_pass++;
    n_total++;
    if (sb_q.size() == 0) $display("FAIL bp_pending_missing got=%h", id_o);
    else begin exp = sb_q.pop_front(); if (id_o !== exp) $display("FAIL bp_pending_result got=%h exp=%h", id_o, exp); else n_pass++; end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_compute();
    int lat;
    logic [63:0] exp;
    @(negedge clk);
    id_g = {16'd1, 16'd2, 16'd3, 16'd4}; id_iv = 1'b1; id_or = 1'b1;
    @(negedge clk); id_iv = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (id_ir !== 1'b1) $display("FAIL rmid_in_ready got=%b exp=1", id_ir); else n_pass++;
    n_total++; if (id_ov !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", id_ov); else n_pass++;
    n_total++; if (id_o !== 64'd0) $display("FAIL rmid_grad_out got=%h exp=0", id_o); else n_pass++;
    id_g = {16'hFFFF, 16'd2, 16'hFFFD, 16'd4}; id_iv = 1'b1;
    if (id_iv && id_ir) sb_q.push_back({16'hFFFF, 16'd2, 16'hFFFD, 16'd4});
    @(negedge clk); id_iv = 1'b0;
    lat = 0;
    while (id_ov !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_total++; if (lat != 16) $display("FAIL rmid_latency got=%0d exp=16", lat); else n_pass++;
    n_total++;
    if (sb_q.size() == 0) $display("FAIL rmid_missing got=%h", id_o);
    else begin exp = sb_q.pop_front(); if (id_o !== exp) $display("FAIL rmid_result got=%h exp=%h", id_o, exp); else n_pass++; end
    @(negedge clk);
  endtask

  task automatic drive_rnd();
    int sent = 0;
    int cyc = 0;
    logic fire = 1'b0;
    logic [63:0] gv = '0;
    rnd_iv = 1'b0;
    while (sent < N_RND && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (fire) begin rnd_iv = 1'b0; rnd_g = {$urandom(), $urandom()}; fire = 1'b0; end
      if (!rnd_iv && $urandom_range(0, 3) != 0) begin
        gv = {$urandom(), $urandom()}; rnd_g = gv; rnd_iv = 1'b1;
      end
      if (rnd_iv && rnd_ir) begin sb_q.push_back(model_rnd(gv)); sent++; fire = 1'b1; end
    end
    @(negedge clk); rnd_iv = 1'b0;
  endtask

  task automatic monitor_rnd();
    int got = 0;
    int cyc = 0;
    logic [63:0] exp;
    while (got < N_RND && cyc < 20000) begin
      @(negedge clk); cyc++;
      rnd_or = 1'($urandom_range(0, 1));
      if (rnd_ov && rnd_or) begin
        got++;
        n_total++;
        if (sb_q.size() == 0) $display("FAIL rnd_unexpected got=%h", rnd_o);
        else begin
          exp = sb_q.pop_front();
          if (rnd_o !== exp) $display("FAIL rnd_result n=%0d got=%h exp=%h", got, rnd_o, exp); else n_pass++;
        end
      end
    end
    n_total++; if (got != N_RND) $display("FAIL rnd_count got=%0d exp=%0d", got, N_RND); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    fork
      drive_rnd();
      monitor_rnd();
    join
    n_total++; if (sb_q.size() != 0) $display("FAIL rnd_leftover got=%0d exp=0", sb_q.size()); else n_pass++;
    rnd_or = 1'b1;
    repeat (30) begin @(negedge clk); if (rnd_ov) extra++; end
    n_total++; if (extra != 0) $display("FAIL rnd_duplicate got=%0d exp=0", extra); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    id_g = '0; id_iv = 1'b0; id_or = 1'b0;
    d23_g = '0; d23_iv = 1'b0; d23_or = 1'b0;
    s0_g = '0; s1_g = '0; s2_g = '0; s_iv = 1'b0; s_or = 1'b0;
    rnd_g = '0; rnd_iv = 1'b0; rnd_or = 1'b0;
    test_reset();
    test_identity();
    test_nin2_nout3();
    test_signed_wrap();
    test_backpressure();
    test_reset_mid_compute();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/linear_layer_backprop.md
# linear_layer_backprop

Sequential backward-pass engine for one linear layer. It accepts an output-gradient vector `g` of length NOUT and returns the input-gradient vector `W^T·g` of length NIN, using the same flattened weight matrix that parameterises the forward layer. It uses a single multiply-accumulate unit over NIN·NOUT cycles, with valid/ready handshakes on both sides. One instance is placed per forward layer, chained in reverse order to backpropagate through the network.

## Interface

Parameters:

- WIDTH, 16: bit width of every signed element, weight and result.
- NIN, 4: forward-layer input size, which is also the length of `grad_out`.
- NOUT, 4: forward-layer output size, which is also the length of `grad_in`.
- WEIGHTS_MATRIX_FLAT, all zeros, width WIDTH·NIN·NOUT: forward weight `w[o][i]` sits at bits `[WIDTH*(o*NIN+i) +: WIDTH]`.

Ports (clock and reset first):

- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- grad_in, input, signed [WIDTH-1:0] [0:NOUT-1]: output-gradient vector.
- in_valid, input, 1: `grad_in` is valid.
- in_ready, output, 1: block can accept a vector.
- grad_out, output, signed [WIDTH-1:0] [0:NIN-1]: input-gradient result.
- out_valid, output, 1: `grad_out` holds a completed result.
- out_ready, input, 1: downstream accepts the result.

## Operation

- States:
  - IDLE: in_ready=1, out_valid=0.
  - COMPUTE: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready and out_valid decode directly from state, with no combinational path from any input.
- IDLE → COMPUTE on an edge with in_valid && in_ready:
  - latch grad_in into an internal vector `g`;
  - clear the accumulator;
  - set i=0, o=0.
  - With in_valid low, stay in IDLE.
- COMPUTE performs one MAC per edge: `acc ← acc + w[o][i]·g[o]`.
  - o increments from 0 to NOUT-1.
  - When o==NOUT-1: the sum including this term is written to result buffer element i; acc clears; o wraps to 0; i increments.
  - The edge with i==NIN-1 and o==NOUT-1 copies the full result buffer to grad_out and moves to DONE.
- DONE → IDLE on an edge with out_valid && out_ready. With out_ready low, DONE holds indefinitely and grad_out stays stable.
- No overlap: the next grad_in cannot be accepted until the cycle after the output handshake.
- Arithmetic:
  - each product is a full 2·WIDTH signed value;
  - the accumulator is 2·WIDTH + clog2(NOUT)+1 bits signed, so no internal overflow occurs;
  - the result is the low WIDTH bits of the exact sum (two's-complement wrap), matching integer semantics of the forward layer;
  - no saturation, no rounding.
- grad_out changes only on the completing edge of COMPUTE and on reset. It holds the last result while in IDLE and COMPUTE.
- Changes to grad_in after acceptance have no effect on the result.
- NIN=1 or NOUT=1 are legal. The cycle count formula still holds, with a minimum of 1 compute cycle.

## Timing

- Reset values:
  - state=IDLE, so in_ready=1 and out_valid=0;
  - grad_out all elements 0;
  - acc, i, o, g, and the result buffer all 0.
- Reset mid-COMPUTE or in DONE aborts the vector. The next cycle is IDLE with grad_out=0 and the pending result discarded.
- Reset takes priority over any simultaneous handshake.
- Latency: with input handshake at edge E0, the completing edge is E(NIN·NOUT), and out_valid is high in the cycle after it. Default parameters give 16 cycles.
- Throughput with out_ready tied high is one vector per NIN·NOUT+2 cycles: one COMPUTE span, one DONE cycle, one IDLE cycle.
- in_valid asserted during COMPUTE or DONE is ignored. The source must hold the vector until in_ready is seen.

## Test plan

- Identity weights, NIN=NOUT=4, g={1,2,3,4}, out_ready=1:
  - grad_out must be {1,2,3,4};
  - out_valid must rise exactly 16 cycles after the accept edge and stay high for exactly 1 cycle.
- NIN=2, NOUT=3, rows w[0]={1,2}, w[1]={3,4}, w[2]={5,6}, g={1,1,1}: grad_out must be {9,12}, after 6 cycles of latency.
- Signed and wrap behaviour, WIDTH=16, NIN=NOUT=1:
  - w=-3, g=7 must give -21;
  - w=16384, g=4 must give 0 (65536 wraps);
  - w=-32768, g=-1 must give -32768.
- Backpressure:
  - Hold out_ready low for 10 cycles in DONE. out_valid must stay 1, grad_out must stay stable, and in_ready must stay 0.
  - A new in_valid pulse during that time must be ignored.
  - Release out_ready. The block must return to IDLE the next cycle, then accept the pending vector.
- Reset at the 5th COMPUTE cycle: the next cycle must show in_ready=1, out_valid=0 and grad_out all 0. A fresh vector must then produce the correct result.
- Back-to-back random weights and g, 100 vectors, with in_valid and out_ready toggled randomly: every grad_out must equal the wrapped `W^T·g` from a reference model, with no dropped or duplicated vectors.
